// File: rtl/bcd_to_unsigned_if.sv
// Trigger/idle handshake and result bundle for the BCD-to-binary converter.
// The master drives requests; the slave (converter) returns status and result.
interface bcd_to_unsigned_if #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
);
    logic                    trigger;
    logic [4*N_DIGITS-1:0]   bcd;
    logic                    idle;
    logic [BIN_W-1:0]        out;
    logic                    done;
    logic                    err;

    modport master (
        output trigger, bcd,
        input  idle, out, done, err
    );

    modport slave (
        input  trigger, bcd,
        output idle, out, done, err
    );
endinterface

// File: rtl/bcd_to_unsigned.sv
// Multi-cycle packed-BCD to unsigned binary converter (reverse double dabble).
// Rejects requests containing a non-decimal digit with a single-cycle err/done.
module bcd_to_unsigned #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
) (
    input logic              clk,
    input logic              reset,
    bcd_to_unsigned_if.slave bus
);
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(BCD_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BCD_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_SUB3  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [BCD_W-1:0] dig;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] dig_sub;
    logic [BCD_W-1:0] dig_sh;
    logic [BCD_W-1:0] acc_sh;
    logic [CNT_W-1:0] count;
    logic [BIN_W-1:0] out_q;
    logic             done_q;
    logic             err_q;
    logic             bad;
    logic             last;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) bad = 1'b1;
        end
    end

    // Per-digit correction; wraps within the nibble, no borrow between digits
    always_comb begin
        dig_sub = dig;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (dig[4*i +: 4] >= 4'd8) begin
                dig_sub[4*i +: 4] = dig[4*i +: 4] - 4'd3;
            end
        end
    end

    assign dig_sh = {1'b0, dig[BCD_W-1:1]};
    assign acc_sh = {dig[0], acc[BCD_W-1:1]};
    assign last   = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (bus.trigger && !bad) state_nx = S_SHIFT;
            S_SHIFT: state_nx = last ? S_IDLE : S_SUB3;
            S_SUB3:  state_nx = S_SHIFT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.idle = (state == S_IDLE);
        bus.out  = out_q;
        bus.done = done_q;
        bus.err  = err_q;
    end

    // After the final shift the value sits right-aligned in acc
    always_ff @(posedge clk) begin
        if (reset) begin
            dig    <= '0;
            acc    <= '0;
            count  <= '0;
            out_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.trigger) begin
                        if (bad) begin
                            err_q  <= 1'b1;
                            out_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            dig   <= bus.bcd;
                            acc   <= '0;
                            count <= CNT_W'(1);
                        end
                    end
                end
                S_SHIFT: begin
                    dig <= dig_sh;
                    acc <= acc_sh;
                    if (last) begin
                        out_q  <= acc_sh[BIN_W-1:0];
                        done_q <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                S_SUB3: dig <= dig_sub;
                default: ;
            endcase
        end
    end
endmodule
